id_stage_ctrl: RTL and testbench
================================

ID_STAGE_CTRL -- requirements
Module: id_stage_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall and flush performance counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_valid  input  1  fetch stage presents an instruction.
REQ-005 if_inst  input  32  fetched instruction word.
REQ-006 if_pc  input  32  fetched instruction PC.
REQ-007 if_ready  output  1  ID accepts fetch data this cycle.
REQ-008 ex_ready  input  1  EX stage accepts ID output this cycle.
REQ-009 ex_mem_read  input  1  instruction now in EX is a load.
REQ-010 ex_rd  input  5  destination register of the instruction in EX.
REQ-011 flush  input  1  taken branch/jump redirect from EX; squashes ID.
REQ-012 cnt_clr  input  1  synchronous clear of both counters.
REQ-013 id_valid  output  1  ID output valid to EX.
REQ-014 id_inst / id_pc  output  32 / 32  registered instruction and PC.
REQ-015 imm_sel  output  3  immediate-format select for the sign extender.
REQ-016 id_illegal  output  1  registered opcode unrecognised.
REQ-017 stall_cnt / flush_cnt  output  CNT_W / CNT_W  saturating event counters.

Function
REQ-018 The block SHALL be a two-state FSM: EMPTY (no held instruction), FULL (instruction held in the ID register).
REQ-019 imm_sel SHALL decode from id_inst[6:0]: 0000011/0010011/1100111 -> 000 (I); 0100011 -> 001 (S); 1100011 -> 010 (B); 0110111/0010111 -> 011 (U); 1101111 -> 100 (J); 0110011 and all others -> 111 (none).
REQ-020 id_illegal SHALL be 1 in FULL when the opcode is none of the nine listed in REQ-019; the instruction still flows with the flag set.
REQ-021 rs1 (inst[19:15]) is used by I, S, B, R formats; rs2 (inst[24:20]) by S, B, R; U and J use neither.
REQ-022 hazard SHALL equal FULL and ex_mem_read and ex_rd != 0 and a used rs field equals ex_rd.
REQ-023 id_valid SHALL equal FULL and not hazard and not flush; fire = id_valid and ex_ready.
REQ-024 if_ready SHALL equal (EMPTY or fire) or flush.
REQ-025 Capture (if_valid and if_ready and not flush) SHALL load id_inst/id_pc in one cycle and enter or stay in FULL.
REQ-026 In FULL, fire without capture SHALL go to EMPTY; no fire SHALL hold id_inst/id_pc unchanged (hazard stall or EX back-pressure).
REQ-027 flush SHALL have highest priority: next state EMPTY, concurrent fetch data accepted and discarded, id_valid 0 in the flush cycle.
REQ-028 A load-use hazard SHALL insert exactly one bubble when EX advances the load next cycle; hazard persists while ex_mem_read/ex_rd persist.
REQ-029 stall_cnt SHALL increment by 1 each cycle hazard is 1; flush_cnt each cycle flush is 1; both saturate at all-ones, never wrap.
REQ-030 cnt_clr SHALL zero both counters, taking priority over same-cycle increments.
REQ-031 Decode outputs SHALL be combinational from the ID register; capture-to-id_valid latency is one cycle.

Reset
REQ-032 On rst: state EMPTY, id_inst 0x00000000, id_pc 0x00000000, id_valid 0, imm_sel 111, id_illegal 0, if_ready 1, counters 0.
REQ-033 rst asserted mid-operation SHALL discard the held instruction immediately without waiting for a clock edge.

Structure
REQ-034 Shared package rv_pl_pkg SHALL hold imm_sel encodings (IMM_I..IMM_J, IMM_NONE), RV32I opcode constants, and the FSM state enum.
REQ-035 One combinational sub-module id_decode SHALL map an instruction to imm_sel, uses_rs1, uses_rs2, illegal.

Verification
REQ-036 Fetch 0x00500093 (addi x1,x0,5), ex_ready=1 -> next cycle id_valid=1, imm_sel=000, id_illegal=0.
REQ-037 ID holds 0x002081B3 (add x3,x1,x2), ex_mem_read=1, ex_rd=1 for one cycle -> id_valid=0, if_ready=0, stall_cnt=1, then id_valid=1 with same id_inst.
REQ-038 ID holds 0x0020A023 (sw) and ex_ready=0 for 3 cycles -> imm_sel=001, id_inst held, if_ready=0 throughout.
REQ-039 flush=1 while FULL and if_valid=1 -> next cycle EMPTY, id_valid=0, flush_cnt=1, fetched word dropped.
REQ-040 Hazard held for 2^CNT_W+5 cycles -> stall_cnt saturates at all-ones; cnt_clr=1 with hazard -> 0.
REQ-041 Fetch 0xFFFFFFFF -> id_illegal=1, imm_sel=111; rst asserted mid-cycle -> id_valid=0 immediately.

Source files
------------

// File: rtl/rv_pl_pkg.sv
// Shared pipeline definitions: immediate formats, RV32I major opcodes,
// and ID stage state encoding.
package rv_pl_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_NONE = 3'b111
  } imm_sel_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } id_state_e;

  function automatic logic [6:0] opcode_of(
    input logic [31:0] inst
  );
    return inst[6:0];
  endfunction

endpackage

// File: rtl/id_decode.sv
// Opcode classifier: immediate format, source register usage and
// legality of the major opcode.
import rv_pl_pkg::*;

module id_decode (
  input  logic [6:0] opcode,
  output logic [2:0] imm_sel,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       illegal
);

  always_comb begin
    imm_sel  = IMM_NONE;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    unique case (opcode)
      OP_LOAD,
      OP_IMM,
      OP_JALR: begin
        imm_sel  = IMM_I;
        uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        imm_sel  = IMM_S;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm_sel  = IMM_B;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_LUI,
      OP_AUIPC: begin
        imm_sel = IMM_U;
      end
      OP_JAL: begin
        imm_sel = IMM_J;
      end
      OP_REG: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// ID stage control: single-entry instruction register with load-use
// interlock, flush squash and saturating stall/flush counters.
import rv_pl_pkg::*;

module id_stage_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc,
  output logic             if_ready,
  input  logic             ex_ready,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             id_valid,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc,
  output logic [2:0]       imm_sel,
  output logic             id_illegal,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  id_state_e  state;
  logic [2:0] dec_imm;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       dec_illegal;
  logic       full;
  logic       rs1_hit;
  logic       rs2_hit;
  logic       hazard;
  logic       fire;
  logic       capture;

  id_decode u_decode (
    .opcode   (opcode_of(id_inst)),
    .imm_sel  (dec_imm),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .illegal  (dec_illegal)
  );

  assign full    = (state == ST_FULL);
  assign rs1_hit = uses_rs1 && (id_inst[19:15] == ex_rd);
  assign rs2_hit = uses_rs2 && (id_inst[24:20] == ex_rd);

  // x0 is never a real producer, so a load to x0 cannot interlock.
  assign hazard = full && ex_mem_read
               && (ex_rd != 5'd0)
               && (rs1_hit || rs2_hit);

  assign id_valid   = full && !hazard && !flush;
  assign fire       = id_valid && ex_ready;
  assign if_ready   = !full || fire || flush;
  assign capture    = if_valid && if_ready && !flush;
  assign imm_sel    = dec_imm;
  assign id_illegal = full && dec_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_EMPTY;
      id_inst <= '0;
      id_pc   <= '0;
    end else begin
      unique case (1'b1)
        flush: begin
          state <= ST_EMPTY;
        end
        capture: begin
          state   <= ST_FULL;
          id_inst <= if_inst;
          id_pc   <= if_pc;
        end
        fire: begin
          state <= ST_EMPTY;
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl: handshake, interlock, flush,
// decode table, counter saturation and asynchronous reset.
module tb_id_stage_ctrl;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] SAT = '1;

  logic             clk;
  logic             rst;
  logic             if_valid;
  logic [31:0]      if_inst;
  logic [31:0]      if_pc;
  logic             if_ready;
  logic             ex_ready;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             flush;
  logic             cnt_clr;
  logic             id_valid;
  logic [31:0]      id_inst;
  logic [31:0]      id_pc;
  logic [2:0]       imm_sel;
  logic             id_illegal;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_checks;
  int n_fail;

  id_stage_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_ready    (if_ready),
    .ex_ready    (ex_ready),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .flush       (flush),
    .cnt_clr     (cnt_clr),
    .id_valid    (id_valid),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .imm_sel     (imm_sel),
    .id_illegal  (id_illegal),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (if_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_if_ready: got %b want 1", if_ready);
    end
    n_checks++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_id_valid: got %b want 0", id_valid);
    end
    n_checks++;
    if (imm_sel !== 3'b111 || id_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_decode: got imm %b ill %b want 111 0",
               imm_sel, id_illegal);
    end
    n_checks++;
    if (id_inst !== 32'h0 || id_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_regs: got %h %h want 0 0", id_inst, id_pc);
    end
    n_checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      n_fail++;
      $display("FAIL rst_cnt: got %0d %0d want 0 0",
               stall_cnt, flush_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_addi();
    if_valid = 1'b1;
    if_inst  = 32'h00500093;
    if_pc    = 32'h00000100;
    ex_ready = 1'b1;
    #1;
    n_checks++;
    if (if_ready !== 1'b1 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_pre: got rdy %b vld %b want 1 0",
               if_ready, id_valid);
    end
    tick();
    if_valid = 1'b0;
    #1;
    n_checks++;
    if (id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL addi_valid: got %b want 1", id_valid);
    end
    n_checks++;
    if (imm_sel !== 3'b000 || id_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_decode: got imm %b ill %b want 000 0",
               imm_sel, id_illegal);
    end
    n_checks++;
    if (id_inst !== 32'h00500093 || id_pc !== 32'h00000100) begin
      n_fail++;
      $display("FAIL addi_regs: got %h %h want 00500093 00000100",
               id_inst, id_pc);
    end
    tick();
    n_checks++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_drain: got %b want 0", id_valid);
    end
  endtask

  task automatic test_load_use();
    if_valid = 1'b1;
    if_inst  = 32'h002081B3;
    if_pc    = 32'h00000104;
    tick();
    if_valid    = 1'b0;
    ex_mem_read = 1'b1;
    ex_rd       = 5'd1;
    #1;
    n_checks++;
    if (id_valid !== 1'b0 || if_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_stall: got vld %b rdy %b want 0 0",
               id_valid, if_ready);
    end
    tick();
    ex_mem_read = 1'b0;
    ex_rd       = 5'd0;
    #1;
    n_checks++;
    if (stall_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL lu_cnt: got %0d want 1", stall_cnt);
    end
    n_checks++;
    if (id_valid !== 1'b1 || id_inst !== 32'h002081B3) begin
      n_fail++;
      $display("FAIL lu_resume: got vld %b inst %h want 1 002081b3",
               id_valid, id_inst);
    end
    ex_mem_read = 1'b1;
    ex_rd       = 5'd2;
    #1;
    n_checks++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_rs2: got %b want 0", id_valid);
    end
    ex_rd = 5'd3;
    #1;
    n_checks++;
    if (id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_rd_only: got %b want 1", id_valid);
    end
    ex_rd = 5'd0;
    #1;
    n_checks++;
    if (id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_x0: got %b want 1", id_valid);
    end
    ex_mem_read = 1'b0;
    tick();
    n_checks++;
    if (id_valid !== 1'b0 || stall_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL lu_drain: got vld %b cnt %0d want 0 1",
               id_valid, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    if_valid = 1'b1;
    if_inst  = 32'h0020A023;
    if_pc    = 32'h00000108;
    ex_ready = 1'b0;
    tick();
    if_inst = 32'h00000013;
    if_pc   = 32'h0000010C;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (imm_sel !== 3'b001 || id_inst !== 32'h0020A023) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got imm %b inst %h want 001 0020a023",
                 i, imm_sel, id_inst);
      end
      n_checks++;
      if (if_ready !== 1'b0 || id_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hs[%0d]: got rdy %b vld %b want 0 1",
                 i, if_ready, id_valid);
      end
      tick();
    end
    if_valid = 1'b0;
    ex_ready = 1'b1;
    #1;
    n_checks++;
    if (id_pc !== 32'h00000108) begin
      n_fail++;
      $display("FAIL bp_pc: got %h want 00000108", id_pc);
    end
    tick();
    n_checks++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got %b want 0", id_valid);
    end
  endtask

  task automatic test_flush();
    if_valid = 1'b1;
    if_inst  = 32'h00500093;
    if_pc    = 32'h00000200;
    ex_ready = 1'b0;
    tick();
    flush   = 1'b1;
    if_inst = 32'h00A00113;
    if_pc   = 32'h00000204;
    #1;
    n_checks++;
    if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_cycle: got vld %b rdy %b want 0 1",
               id_valid, if_ready);
    end
    tick();
    flush    = 1'b0;
    if_valid = 1'b0;
    #1;
    n_checks++;
    if (id_valid !== 1'b0 || flush_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL fl_after: got vld %b cnt %0d want 0 1",
               id_valid, flush_cnt);
    end
    n_checks++;
    if (id_inst !== 32'h00500093 || id_pc !== 32'h00000200) begin
      n_fail++;
      $display("FAIL fl_drop: got %h %h want 00500093 00000200",
               id_inst, id_pc);
    end
    ex_ready = 1'b1;
  endtask

  task automatic test_decode();
    logic [31:0] insts [9];
    logic [2:0]  imms  [9];
    logic        ills  [9];
    insts = '{32'hFFFFFFFF, 32'h12345037, 32'h00000017,
              32'h0000006F, 32'h00208463, 32'h00008067,
              32'h0000A103, 32'h00000033, 32'h0000000B};
    imms  = '{3'b111, 3'b011, 3'b011, 3'b100, 3'b010,
              3'b000, 3'b000, 3'b111, 3'b111};
    ills  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b1};
    ex_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if_valid = 1'b1;
      if_inst  = insts[i];
      if_pc    = 32'h00000400 + 32'(4 * i);
      tick();
      if_valid = 1'b0;
      #1;
      n_checks++;
      if (imm_sel !== imms[i] || id_illegal !== ills[i]
          || id_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL dec[%0d]: got imm %b ill %b vld %b want %b %b 1",
                 i, imm_sel, id_illegal, id_valid, imms[i], ills[i]);
      end
      tick();
    end
    n_checks++;
    if (id_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_empty_ill: got %b want 0", id_illegal);
    end
  endtask

  task automatic test_saturation();
    if_valid = 1'b1;
    if_inst  = 32'h002081B3;
    if_pc    = 32'h00000500;
    ex_ready = 1'b0;
    cnt_clr  = 1'b1;
    tick();
    if_valid = 1'b0;
    cnt_clr  = 1'b0;
    #1;
    n_checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      n_fail++;
      $display("FAIL sat_clr0: got %0d %0d want 0 0",
               stall_cnt, flush_cnt);
    end
    ex_mem_read = 1'b1;
    ex_rd       = 5'd2;
    repeat ((2 ** CNT_W) + 5) tick();
    #1;
    n_checks++;
    if (stall_cnt !== SAT) begin
      n_fail++;
      $display("FAIL sat_top: got %0d want %0d", stall_cnt, SAT);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #1;
    n_checks++;
    if (stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL sat_clr_pri: got %0d want 0", stall_cnt);
    end
    tick();
    n_checks++;
    if (stall_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL sat_resume: got %0d want 1", stall_cnt);
    end
    ex_mem_read = 1'b0;
    ex_rd       = 5'd0;
    ex_ready    = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    if_valid = 1'b1;
    if_inst  = 32'h00500093;
    if_pc    = 32'h00000300;
    ex_ready = 1'b0;
    tick();
    if_valid = 1'b0;
    #1;
    n_checks++;
    if (id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_pre: got %b want 1", id_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_now: got vld %b rdy %b want 0 1",
               id_valid, if_ready);
    end
    n_checks++;
    if (id_inst !== 32'h0 || stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL ar_clear: got inst %h cnt %0d want 0 0",
               id_inst, stall_cnt);
    end
    #1;
    rst = 1'b0;
    tick();
    n_checks++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_after: got %b want 0", id_valid);
    end
  endtask

  initial begin
    clk         = 1'b0;
    rst         = 1'b1;
    if_valid    = 1'b0;
    if_inst     = '0;
    if_pc       = '0;
    ex_ready    = 1'b0;
    ex_mem_read = 1'b0;
    ex_rd       = '0;
    flush       = 1'b0;
    cnt_clr     = 1'b0;
    n_checks    = 0;
    n_fail      = 0;
    test_reset();
    test_addi();
    test_load_use();
    test_backpressure();
    test_flush();
    test_decode();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
